// File: rtl/cnt_capture.sv
// -----------------------------------------------------------------------------
// cnt_capture
//
// Captures snapshots of an upstream free-running counter into a small FIFO.
// An entry is written either on a software request (capture_i) or on a rising
// edge of the upstream overflow flag. Each entry is tagged with its source so
// the consumer can tell the two apart. Overflow events are also counted in a
// saturating statistics counter, and a sticky flag records any lost capture.
//
// Ports
//   clk         : single clock, all state updates on the rising edge
//   reset_n     : asynchronous active-low reset
//   cnt_i       : upstream counter value [WIDTH-1:0]
//   ovf_i       : upstream overflow flag (level or pulse)
//   capture_i   : software capture request for the current cycle
//   clear_i     : synchronous flush of the FIFO and all statistics
//   rd_ready_i  : consumer accepts rd_data_o this cycle
//   rd_valid_o  : rd_data_o holds the oldest unread entry
//   rd_data_o   : {src, value}, src=1 for overflow capture, 0 for capture_i
//   level_o     : number of stored entries
//   full_o      : FIFO holds DEPTH entries
//   drop_o      : sticky, set when a capture was lost
//   ovf_cnt_o   : saturating count of overflow events
// -----------------------------------------------------------------------------
module cnt_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int OVF_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           cnt_i,
  input  logic                       ovf_i,
  input  logic                       capture_i,
  input  logic                       clear_i,
  input  logic                       rd_ready_i,
  output logic                       rd_valid_o,
  output logic [WIDTH:0]             rd_data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       drop_o,
  output logic [OVF_W-1:0]           ovf_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH:0]   r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;
  logic             r_drop;
  logic             r_ovfQ;
  logic [OVF_W-1:0] r_ovfCnt;

  logic             w_ovfEvt;
  logic             w_wrReq;
  logic             w_full;
  logic             w_rdValid;
  logic             w_rdFire;
  logic             w_wrFire;
  logic             w_dropEvt;
  logic [WIDTH:0]   w_wrData;

  // Overflow event is a rising edge of ovf_i against its registered copy.
  // The source tag follows the overflow event, so a coincident software
  // capture collapses into a single overflow-tagged entry.
  always_comb begin
    w_ovfEvt  = ovf_i & ~r_ovfQ;
    w_wrReq   = w_ovfEvt | capture_i;
    w_full    = (r_level == LW'(DEPTH));
    w_rdValid = (r_level != '0);
    w_rdFire  = w_rdValid & rd_ready_i;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    w_wrFire  = w_wrReq & (~w_full | w_rdFire);
    w_dropEvt = w_wrReq & w_full & ~w_rdFire;
    w_wrData  = {w_ovfEvt, cnt_i};
  end

  // Storage array is left unreset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_wrFire && !clear_i) begin
      r_mem[r_wrPtr] <= w_wrData;
    end
  end

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
  // modulo DEPTH without extra logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else if (clear_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_wrFire) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_rdFire) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_wrFire, w_rdFire})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Edge-detect register keeps tracking ovf_i through a clear so that a
  // flag held high across the clear is not seen as a fresh event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovfQ <= 1'b0;
    end else begin
      r_ovfQ <= ovf_i;
    end
  end

  // Statistics: sticky drop flag and saturating overflow counter. Overflow
  // events count regardless of whether their FIFO write was accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop   <= 1'b0;
      r_ovfCnt <= '0;
    end else if (clear_i) begin
      r_drop   <= 1'b0;
      r_ovfCnt <= '0;
    end else begin
      if (w_dropEvt) begin
        r_drop <= 1'b1;
      end
      if (w_ovfEvt && (r_ovfCnt != '1)) begin
        r_ovfCnt <= r_ovfCnt + OVF_W'(1);
      end
    end
  end

  assign rd_valid_o = w_rdValid;
  assign rd_data_o  = r_mem[r_rdPtr];
  assign level_o    = r_level;
  assign full_o     = w_full;
  assign drop_o     = r_drop;
  assign ovf_cnt_o  = r_ovfCnt;

endmodule

// File: tb/tb_cnt_capture.sv
// -----------------------------------------------------------------------------
// tb_cnt_capture
//
// Directed bench for cnt_capture. The stimulus process pushes the expected
// {src, value} of every accepted write into a queue; an independent monitor
// pops and compares whenever a read handshake is presented. Status outputs
// are compared against hand-computed constants. The overflow counter is built
// 8 bits wide here so that saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_cnt_capture;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int OVF_W = 8;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] cnt_i;
  logic             ovf_i;
  logic             capture_i;
  logic             clear_i;
  logic             rd_ready_i;
  logic             rd_valid_o;
  logic [WIDTH:0]   rd_data_o;
  logic [2:0]       level_o;
  logic             full_o;
  logic             drop_o;
  logic [OVF_W-1:0] ovf_cnt_o;

  int total = 0;
  int bad   = 0;
  logic [WIDTH:0] expQ [$];

  cnt_capture #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .OVF_W (OVF_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cnt_i      (cnt_i),
    .ovf_i      (ovf_i),
    .capture_i  (capture_i),
    .clear_i    (clear_i),
    .rd_ready_i (rd_ready_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .level_o    (level_o),
    .full_o     (full_o),
    .drop_o     (drop_o),
    .ovf_cnt_o  (ovf_cnt_o)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic cap, input logic ovf, input logic clr,
                               input logic rdy, input logic [WIDTH-1:0] cnt);
    capture_i  = cap;
    ovf_i      = ovf;
    clear_i    = clr;
    rd_ready_i = rdy;
    cnt_i      = cnt;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every read handshake pops the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && !clear_i && rd_valid_o && rd_ready_i) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL readUnexpected: got 0x%0h expected no entry", rd_data_o);
      end else begin
        checkOutput("readData", 32'(rd_data_o), 32'(expQ.pop_front()));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #12;
    checkOutput("resetValid", 32'(rd_valid_o), 32'd0);
    checkOutput("resetLevel", 32'(level_o), 32'd0);
    checkOutput("resetFull", 32'(full_o), 32'd0);
    checkOutput("resetDrop", 32'(drop_o), 32'd0);
    checkOutput("resetOvfCnt", 32'(ovf_cnt_o), 32'd0);
    tick();
    reset_n = 1'b1;

    // Single software capture, then read it out.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
    expQ.push_back(9'h010);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h10);
    checkOutput("capValid", 32'(rd_valid_o), 32'd1);
    checkOutput("capLevel", 32'(level_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h10);
    checkOutput("capLevelAfterRead", 32'(level_o), 32'd0);

    // Overflow held high for five cycles gives exactly one event.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    expQ.push_back(9'h100);
    repeat (5) tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("ovfHoldLevel", 32'(level_o), 32'd1);
    checkOutput("ovfHoldCnt", 32'(ovf_cnt_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Five captures into a four-entry FIFO: the fifth is dropped.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
      if (i <= 4) expQ.push_back(9'(i));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("fillLevel", 32'(level_o), 32'd4);
    checkOutput("fillFull", 32'(full_o), 32'd1);
    checkOutput("fillDrop", 32'(drop_o), 32'd1);

    // Full FIFO with simultaneous read and write keeps level at DEPTH.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h2A);
    expQ.push_back(9'h02A);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("rwFullLevel", 32'(level_o), 32'd4);
    checkOutput("rwFullFull", 32'(full_o), 32'd1);
    repeat (4) tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("drainLevel", 32'(level_o), 32'd0);
    checkOutput("drainValid", 32'(rd_valid_o), 32'd0);
    checkOutput("dropSticky", 32'(drop_o), 32'd1);

    // Overflow edge coinciding with a software capture: one tagged entry.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h7F);
    expQ.push_back(9'h17F);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("coincLevel", 32'(level_o), 32'd1);
    checkOutput("coincOvfCnt", 32'(ovf_cnt_o), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);

    // Drive the overflow counter to saturation; only the first four
    // overflow captures fit, the rest are dropped but still counted.
    for (int k = 0; k < 253; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'(k));
      if (k < 4) expQ.push_back({1'b1, 8'(k)});
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'(k));
      tick();
    end
    checkOutput("satOvfCnt", 32'(ovf_cnt_o), 32'hFF);
    checkOutput("satLevel", 32'(level_o), 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
    tick();
    checkOutput("satHold", 32'(ovf_cnt_o), 32'hFF);

    // Clear wins over a same-cycle capture and flushes everything.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h66);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    expQ.delete();
    checkOutput("clearOvfCnt", 32'(ovf_cnt_o), 32'd0);
    checkOutput("clearLevel", 32'(level_o), 32'd0);
    checkOutput("clearDrop", 32'(drop_o), 32'd0);
    checkOutput("clearValid", 32'(rd_valid_o), 32'd0);

    // Mid-operation reset discards entries without waiting for a clock.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h44);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("preResetLevel", 32'(level_o), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncResetLevel", 32'(level_o), 32'd0);
    checkOutput("asyncResetValid", 32'(rd_valid_o), 32'd0);

    // Overflow already high at reset release counts as one event.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hCC);
    tick();
    reset_n = 1'b1;
    expQ.push_back(9'h1CC);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hCD);
    checkOutput("postResetOvfCnt", 32'(ovf_cnt_o), 32'd1);
    checkOutput("postResetLevel", 32'(level_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("finalLevel", 32'(level_o), 32'd0);
    checkOutput("finalOvfCnt", 32'(ovf_cnt_o), 32'd1);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
